// File: rtl/dma_axi_read_channel.sv
// Read-side AXI4 master of the DMA engine: turns a 2-D descriptor into AR bursts
// and forwards R beats to the data buffer, tagging the last beat of every line.
module dma_axi_read_channel #(
    parameter int unsigned BW_ADDR        = 32,
    parameter int unsigned BW_AXI_DATA    = 32,
    parameter int unsigned BW_AXI_TID     = 4,
    parameter int unsigned BW_LINE_SIZE   = 16,
    parameter int unsigned BW_NUM_LINES   = 16,
    parameter int unsigned MAX_AXI_LENGTH = 16,
    parameter int unsigned TAG_DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rstnn,
    input  logic [BW_ADDR-1:0]      cfg_addr,
    input  logic [BW_LINE_SIZE-1:0] cfg_line_size,
    input  logic [BW_NUM_LINES-1:0] cfg_num_lines,
    input  logic [BW_ADDR-1:0]      cfg_stride,
    input  logic                    cfg_fixed,
    input  logic                    go,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [BW_AXI_TID-1:0]   arid,
    output logic [BW_ADDR-1:0]      araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [BW_AXI_TID-1:0]   rid,
    input  logic [BW_AXI_DATA-1:0]  rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic                    buf_valid,
    output logic [BW_AXI_DATA:0]    buf_data,
    input  logic                    buf_ready
);

    localparam int unsigned BPB     = BW_AXI_DATA / 8;
    localparam int unsigned LOG_BPB = $clog2(BPB);
    localparam int unsigned BW_CNT  = $clog2(TAG_DEPTH + 1);
    localparam int unsigned BW_PTR  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN} state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic                    r_arvalid;
    logic [BW_ADDR-1:0]      r_araddr;
    logic [7:0]              r_arlen;
    logic                    r_ar_eol;
    logic                    r_fixed;
    logic [BW_ADDR-1:0]      r_stride;
    logic [BW_LINE_SIZE-1:0] r_line_beats;
    // Source of the next burst to present: address, line start, beats and lines left
    logic [BW_ADDR-1:0]      r_addr;
    logic [BW_ADDR-1:0]      r_line_start;
    logic [BW_LINE_SIZE-1:0] r_beats_left;
    logic [BW_NUM_LINES-1:0] r_lines_left;

    logic [TAG_DEPTH-1:0]    r_tag;
    logic [BW_PTR-1:0]       r_wr_ptr;
    logic [BW_PTR-1:0]       r_rd_ptr;
    logic [BW_CNT-1:0]       r_cnt;

    logic                    w_idle;
    logic                    w_cfg_ok;
    logic [BW_LINE_SIZE-1:0] w_cfg_beats;
    logic [BW_ADDR-1:0]      w_src_addr;
    logic [BW_ADDR-1:0]      w_src_line_start;
    logic [BW_ADDR-1:0]      w_src_stride;
    logic [BW_LINE_SIZE-1:0] w_src_beats;
    logic [BW_LINE_SIZE-1:0] w_src_line_beats;
    logic [BW_NUM_LINES-1:0] w_src_lines;
    logic                    w_src_fixed;
    logic [12:0]             w_bnd4k;
    logic [12:0]             w_cap;
    logic [BW_LINE_SIZE-1:0] w_len;
    logic [BW_LINE_SIZE-1:0] w_rem;
    logic                    w_eol;
    logic [BW_ADDR-1:0]      w_next_line_start;
    logic [BW_ADDR-1:0]      w_next_addr;
    logic                    w_ar_hs;
    logic                    w_r_hs;
    logic                    w_pop;
    logic [BW_CNT-1:0]       w_cnt_nxt;
    logic                    w_room;
    logic                    w_load;
    logic                    w_tag_head;
    logic                    w_unused_rid;

    function automatic logic [BW_PTR-1:0] ptr_inc(input logic [BW_PTR-1:0] p);
        return (32'(p) == TAG_DEPTH - 1) ? '0 : p + BW_PTR'(1);
    endfunction

    // In IDLE the first burst is computed straight from the cfg inputs
    assign w_idle           = (r_state == S_IDLE);
    assign w_cfg_ok         = (cfg_num_lines != '0) && (cfg_line_size != '0);
    assign w_cfg_beats      = BW_LINE_SIZE'(cfg_line_size >> LOG_BPB);
    assign w_src_addr       = w_idle ? cfg_addr      : r_addr;
    assign w_src_line_start = w_idle ? cfg_addr      : r_line_start;
    assign w_src_stride     = w_idle ? cfg_stride    : r_stride;
    assign w_src_beats      = w_idle ? w_cfg_beats   : r_beats_left;
    assign w_src_line_beats = w_idle ? w_cfg_beats   : r_line_beats;
    assign w_src_lines      = w_idle ? cfg_num_lines : r_lines_left;
    assign w_src_fixed      = w_idle ? cfg_fixed     : r_fixed;

    // Burst length: min(remaining line beats, MAX_AXI_LENGTH, beats to 4 KB boundary for INCR)
    assign w_bnd4k = 13'((13'h1000 - {1'b0, w_src_addr[11:0]}) >> LOG_BPB);
    assign w_cap   = (!w_src_fixed && (w_bnd4k < 13'(MAX_AXI_LENGTH))) ? w_bnd4k : 13'(MAX_AXI_LENGTH);
    assign w_len   = (32'(w_src_beats) <= 32'(w_cap)) ? w_src_beats : BW_LINE_SIZE'(w_cap);
    assign w_rem   = w_src_beats - w_len;
    assign w_eol   = (w_rem == '0);

    assign w_next_line_start = w_src_line_start + w_src_stride;
    assign w_next_addr = w_eol       ? w_next_line_start :
                         w_src_fixed ? w_src_addr :
                                       w_src_addr + (BW_ADDR'(w_len) << LOG_BPB);

    assign w_ar_hs    = r_arvalid & arready;
    assign w_r_hs     = rvalid & buf_ready & r_busy;
    assign w_pop      = w_r_hs & rlast & (r_cnt != '0);
    assign w_cnt_nxt  = r_cnt + BW_CNT'(w_ar_hs) - BW_CNT'(w_pop);
    assign w_room     = (32'(w_cnt_nxt) < TAG_DEPTH);
    assign w_tag_head = r_tag[r_rd_ptr];

    assign w_load = (w_idle & go & w_cfg_ok) |
                    ((r_state == S_ADDR) & (w_ar_hs | ~r_arvalid) & (r_lines_left != '0) & w_room);

    // Control FSM with AR issue and burst bookkeeping
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_ar_eol     <= 1'b0;
            r_fixed      <= 1'b0;
            r_stride     <= '0;
            r_line_beats <= '0;
            r_addr       <= '0;
            r_line_start <= '0;
            r_beats_left <= '0;
            r_lines_left <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_r_hs && (rresp != 2'b00)) r_error <= 1'b1;

            if (w_load) begin
                r_arvalid    <= 1'b1;
                r_araddr     <= w_src_addr;
                r_arlen      <= 8'(w_len - BW_LINE_SIZE'(1));
                r_ar_eol     <= w_eol;
                r_addr       <= w_next_addr;
                r_line_start <= w_eol ? w_next_line_start : w_src_line_start;
                r_beats_left <= w_eol ? w_src_line_beats : w_rem;
                r_lines_left <= w_eol ? w_src_lines - BW_NUM_LINES'(1) : w_src_lines;
            end else if (w_ar_hs) begin
                r_arvalid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_error <= 1'b0;
                        if (!w_cfg_ok) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state      <= S_ADDR;
                            r_busy       <= 1'b1;
                            r_fixed      <= cfg_fixed;
                            r_stride     <= cfg_stride;
                            r_line_beats <= w_cfg_beats;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_ar_hs && (r_lines_left == '0)) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_pop && (r_cnt == BW_CNT'(1))) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag FIFO: one "burst ends a line" bit per outstanding burst
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_tag    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_ar_hs) begin
                r_tag[r_wr_ptr] <= r_ar_eol;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_cnt <= w_cnt_nxt;
        end
    end

    assign w_unused_rid = ^rid;

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign arid      = '0;
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = 3'(LOG_BPB);
    assign arburst   = r_fixed ? 2'b00 : 2'b01;
    assign arvalid   = r_arvalid;
    assign rready    = buf_ready;
    assign buf_valid = rvalid & r_busy;
    assign buf_data  = {rdata, rlast & w_tag_head};

endmodule

// File: tb/tb_dma_axi_read_channel.sv
// Bench for dma_axi_read_channel: AXI slave model, AR/beat scoreboards,
// descriptor vector table plus hand-written corner-case sequences.
module tb_dma_axi_read_channel;

    localparam int unsigned BW_ADDR        = 32;
    localparam int unsigned BW_AXI_DATA    = 32;
    localparam int unsigned BW_AXI_TID     = 4;
    localparam int unsigned BW_LINE_SIZE   = 16;
    localparam int unsigned BW_NUM_LINES   = 16;
    localparam int unsigned MAX_AXI_LENGTH = 16;
    localparam int unsigned TAG_DEPTH      = 2;
    localparam logic [31:0] DMASK          = 32'hA500_0000;

    logic                    clk = 1'b0;
    logic                    rstnn;
    logic [BW_ADDR-1:0]      cfg_addr;
    logic [BW_LINE_SIZE-1:0] cfg_line_size;
    logic [BW_NUM_LINES-1:0] cfg_num_lines;
    logic [BW_ADDR-1:0]      cfg_stride;
    logic                    cfg_fixed;
    logic                    go;
    logic                    busy, done, error;
    logic [BW_AXI_TID-1:0]   arid;
    logic [BW_ADDR-1:0]      araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid, arready;
    logic [BW_AXI_TID-1:0]   rid;
    logic [BW_AXI_DATA-1:0]  rdata;
    logic [1:0]              rresp;
    logic                    rlast, rvalid, rready;
    logic                    buf_valid;
    logic [BW_AXI_DATA:0]    buf_data;
    logic                    buf_ready;

    always #5 clk = ~clk;

    dma_axi_read_channel #(
        .BW_ADDR(BW_ADDR), .BW_AXI_DATA(BW_AXI_DATA), .BW_AXI_TID(BW_AXI_TID),
        .BW_LINE_SIZE(BW_LINE_SIZE), .BW_NUM_LINES(BW_NUM_LINES),
        .MAX_AXI_LENGTH(MAX_AXI_LENGTH), .TAG_DEPTH(TAG_DEPTH)
    ) u_dut (
        .clk(clk), .rstnn(rstnn),
        .cfg_addr(cfg_addr), .cfg_line_size(cfg_line_size), .cfg_num_lines(cfg_num_lines),
        .cfg_stride(cfg_stride), .cfg_fixed(cfg_fixed), .go(go),
        .busy(busy), .done(done), .error(error),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .buf_valid(buf_valid), .buf_data(buf_data), .buf_ready(buf_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        fixed;
    } ar_t;

    typedef struct {
        logic [31:0] addr;
        int          lsz;
        int          nl;
        logic [31:0] stride;
        logic        fixed;
        int          stall;
        int          n_ar;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [7:0]  l0;
        logic [7:0]  l1;
    } vec_t;

    ar_t         exp_ar_q[$];
    logic [32:0] exp_beat_q[$];
    ar_t         slv_q[$];
    vec_t        v[5];

    int checks   = 0;
    int failures = 0;
    int slv_idx  = 0;
    int ar_wait  = 0;
    int err_beat = -1;
    int beat_cnt = 0;
    int ar_cnt   = 0;
    int done_cnt = 0;
    bit rdy_buf  = 1'b1;
    bit chk_go   = 1'b0;
    bit done_exp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, then drive slave/buffer inputs just after posedge
    task automatic step();
        ar_t b;
        @(negedge clk);
        if (chk_go) begin
            chk("busy_after_go", busy, 1);
            chk("arvalid_after_go", arvalid, 1);
            chk("error_clr_on_go", error, 0);
            chk_go = 1'b0;
        end
        if (done_exp) begin
            chk("done_after_last_beat", done, 1);
            chk("busy_fall_with_done", busy, 0);
            done_exp = 1'b0;
        end
        if (done) done_cnt++;
        if (arvalid) begin
            if (exp_ar_q.size() == 0) begin
                chk("unexpected_ar", arvalid, 0);
            end else begin
                chk("araddr", araddr, exp_ar_q[0].addr);
                chk("arlen", arlen, exp_ar_q[0].len);
                chk("arburst", arburst, exp_ar_q[0].fixed ? 2'b00 : 2'b01);
                chk("arsize_arid", {arsize, arid}, {3'd2, 4'd0});
                if (arready) begin
                    b.addr  = araddr;
                    b.len   = arlen;
                    b.fixed = (arburst == 2'b00);
                    slv_q.push_back(b);
                    void'(exp_ar_q.pop_front());
                    ar_cnt++;
                end
            end
        end
        if (rvalid) begin
            chk("buf_valid", buf_valid, 1);
            if (rready) begin
                if (exp_beat_q.size() == 0) begin
                    chk("unexpected_beat", rvalid, 0);
                end else begin
                    chk("buf_data", buf_data, exp_beat_q.pop_front());
                    if (exp_beat_q.size() == 0) done_exp = 1'b1;
                end
                beat_cnt++;
                slv_idx++;
                if (slv_q.size() > 0 && slv_idx > int'(slv_q[0].len)) begin
                    void'(slv_q.pop_front());
                    slv_idx = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (arvalid && ar_wait > 0) begin
            arready = 1'b0;
            ar_wait--;
        end else begin
            arready = (ar_wait == 0);
        end
        buf_ready = rdy_buf;
        if (slv_q.size() > 0) begin
            b      = slv_q[0];
            rvalid = 1'b1;
            rdata  = (b.fixed ? b.addr : b.addr + 32'(slv_idx * 4)) ^ DMASK;
            rlast  = (slv_idx == int'(b.len));
            rresp  = (beat_cnt == err_beat) ? 2'b10 : 2'b00;
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
            rlast  = 1'b0;
            rresp  = 2'b00;
        end
    endtask

    task automatic start_xfer(input logic [31:0] a, input int lsz, input int nl,
                              input logic [31:0] st, input logic fx);
        cfg_addr      = a;
        cfg_line_size = 16'(lsz);
        cfg_num_lines = 16'(nl);
        cfg_stride    = st;
        cfg_fixed     = fx;
        beat_cnt      = 0;
        for (int l = 0; l < nl; l++) begin
            for (int k = 0; k < lsz / 4; k++) begin
                exp_beat_q.push_back({(fx ? a + 32'(l) * st : a + 32'(l) * st + 32'(4 * k)) ^ DMASK,
                                      (k == lsz / 4 - 1)});
            end
        end
        go = 1'b1;
        step();
        go = 1'b0;
        chk_go = 1'b1;
        // Scramble cfg: the transfer must run from the values latched at go
        cfg_addr      = 32'hDEAD_BEEC;
        cfg_line_size = 16'h0004;
        cfg_num_lines = 16'h0007;
        cfg_stride    = 32'h0000_0400;
        cfg_fixed     = ~fx;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt - d0), 1);
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_beats_left"}, 64'(exp_beat_q.size()), 0);
        chk({tag, "_ars_left"}, 64'(exp_ar_q.size()), 0);
        exp_beat_q.delete();
        exp_ar_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ar_t e;
        //        addr        lsz nl stride      fx  stall n_ar a0           a1           l0  l1
        v[0] = '{32'h1000,    64, 1, 32'h0,      1'b0, 0, 1, 32'h1000,    32'h0,       8'd15, 8'd0};
        v[1] = '{32'h1000,    80, 1, 32'h0,      1'b0, 0, 2, 32'h1000,    32'h1040,    8'd15, 8'd3};
        v[2] = '{32'h1FF8,    16, 1, 32'h0,      1'b0, 0, 2, 32'h1FF8,    32'h2000,    8'd1,  8'd1};
        v[3] = '{32'h1FF8,    16, 1, 32'h0,      1'b1, 0, 1, 32'h1FF8,    32'h0,       8'd3,  8'd0};
        v[4] = '{32'h2000,    8,  2, 32'h100,    1'b0, 5, 2, 32'h2000,    32'h2100,    8'd1,  8'd1};

        rstnn = 1'b0; go = 1'b0; cfg_addr = '0; cfg_line_size = '0; cfg_num_lines = '0;
        cfg_stride = '0; cfg_fixed = 1'b0; arready = 1'b0; rid = '0; rdata = '0;
        rresp = 2'b00; rlast = 1'b0; rvalid = 1'b1; buf_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_araddr_arlen", {araddr, arlen}, 0);
        chk("rst_rready_hi", rready, 1);
        chk("idle_buf_valid", buf_valid, 0);
        buf_ready = 1'b0;
        #1;
        chk("rst_rready_lo", rready, 0);
        rvalid = 1'b0;
        buf_ready = 1'b1;
        rstnn = 1'b1;

        foreach (v[i]) begin
            e = '{v[i].a0, v[i].l0, v[i].fixed};
            exp_ar_q.push_back(e);
            if (v[i].n_ar > 1) begin
                e = '{v[i].a1, v[i].l1, v[i].fixed};
                exp_ar_q.push_back(e);
            end
            ar_wait = v[i].stall;
            start_xfer(v[i].addr, v[i].lsz, v[i].nl, v[i].stride, v[i].fixed);
            wait_done($sformatf("vec%0d", i), 300);
            chk($sformatf("vec%0d_error", i), error, 0);
        end

        // Zero line count / zero line size: immediate done, no AR
        for (int z = 0; z < 2; z++) begin
            cfg_num_lines = (z == 0) ? 16'd0 : 16'd3;
            cfg_line_size = (z == 0) ? 16'd64 : 16'd0;
            go = 1'b1;
            step();
            go = 1'b0;
            @(negedge clk);
            chk($sformatf("zero%0d_done", z), done, 1);
            chk($sformatf("zero%0d_busy", z), busy, 0);
            chk($sformatf("zero%0d_arvalid", z), arvalid, 0);
            @(posedge clk);
            #1;
            chk($sformatf("zero%0d_done_clear", z), done, 0);
        end

        // Tag FIFO full: only TAG_DEPTH bursts go out while the buffer stalls
        rdy_buf = 1'b0;
        buf_ready = 1'b0;
        ar_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            e = '{32'h3000 + 32'(16 * i), 8'd0, 1'b0};
            exp_ar_q.push_back(e);
        end
        start_xfer(32'h3000, 4, 4, 32'h10, 1'b0);
        repeat (20) step();
        chk("tagfull_ar_count", 64'(ar_cnt), 2);
        chk("tagfull_arvalid", arvalid, 0);
        chk("tagfull_busy", busy, 1);
        rdy_buf = 1'b1;
        wait_done("tagfifo", 300);
        chk("tagfifo_total_ars", 64'(ar_cnt), 4);

        // SLVERR on beat 2 of 4: error sticks, transfer completes
        err_beat = 1;
        e = '{32'h4000, 8'd3, 1'b0};
        exp_ar_q.push_back(e);
        start_xfer(32'h4000, 16, 1, 32'h0, 1'b0);
        wait_done("slverr", 100);
        chk("slverr_error_set", error, 1);
        err_beat = -1;
        e = '{32'h1000, 8'd15, 1'b0};
        exp_ar_q.push_back(e);
        start_xfer(32'h1000, 64, 1, 32'h0, 1'b0);
        wait_done("after_err", 300);
        chk("after_err_error", error, 0);

        // Reset while issuing addresses
        ar_wait = 1000;
        e = '{32'h5000, 8'd15, 1'b0};
        exp_ar_q.push_back(e);
        start_xfer(32'h5000, 64, 4, 32'h40, 1'b0);
        repeat (3) step();
        rstnn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_arvalid", arvalid, 0);
        chk("midrst_araddr", araddr, 0);
        exp_ar_q.delete();
        exp_beat_q.delete();
        slv_q.delete();
        slv_idx = 0;
        ar_wait = 0;
        chk_go = 1'b0;
        done_exp = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        @(posedge clk);
        #1;
        rstnn = 1'b1;
        e = '{32'h1000, 8'd15, 1'b0};
        exp_ar_q.push_back(e);
        e = '{32'h1040, 8'd3, 1'b0};
        exp_ar_q.push_back(e);
        start_xfer(32'h1000, 80, 1, 32'h0, 1'b0);
        wait_done("post_rst", 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_axi_read_channel.md
# dma_axi_read_channel

Read-side AXI4 master channel of the DMA engine. It turns a 2-D transfer descriptor (start address, line size, line count, line stride) into AR bursts and streams the returned R beats into the DMA data buffer, tagging the last beat of every line. It pairs with the DMA AXI write channel: this block fills the data buffer, the write channel drains it.

## Interface
- BW_ADDR, 32, AXI address width
- BW_AXI_DATA, 32, AXI data width (power of two, ≥8); BPB = BW_AXI_DATA/8 bytes per beat
- BW_AXI_TID, 4, AXI ID width
- BW_LINE_SIZE, 16, line size field width (bytes)
- BW_NUM_LINES, 16, line count field width
- MAX_AXI_LENGTH, 16, maximum beats per burst (1..256)
- TAG_DEPTH, 4, depth of the outstanding-burst tag FIFO
---
- clk  in  1  clock
- rstnn  in  1  asynchronous active-low reset
- cfg_addr  in  BW_ADDR  start address (BPB-aligned)
- cfg_line_size  in  BW_LINE_SIZE  bytes per line (multiple of BPB)
- cfg_num_lines  in  BW_NUM_LINES  number of lines
- cfg_stride  in  BW_ADDR  line-start increment, bytes
- cfg_fixed  in  1  1 = FIXED-burst mode
- go  in  1  start pulse, sampled in IDLE only
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky: any RRESP ≠ OKAY since last go
- arid / araddr / arlen / arsize / arburst / arvalid / arready  out×6, in  AXI AR channel
- rid / rdata / rresp / rlast / rvalid / rready  in×5, out  AXI R channel
- buf_valid  out  1  data beat to buffer
- buf_data  out  BW_AXI_DATA+1  {rdata, line_last}
- buf_ready  in  1  buffer accepts beat

## Operation
- arid = 0, arsize = log2(BPB); arburst = FIXED if cfg_fixed else INCR.
- Config latched on accepted go; inputs may change afterwards.
- States: IDLE → ADDR (issue ARs) → DRAIN (all ARs issued, awaiting R) → IDLE. go with cfg_num_lines=0 or cfg_line_size=0: done pulse, no AR, back to IDLE.
- Beats per line = cfg_line_size >> log2(BPB). Per burst, INCR: len = min(remaining line beats, MAX_AXI_LENGTH, beats to next 4 KB boundary = (4096 − addr[11:0]) >> log2(BPB)). FIXED: min(remaining, MAX_AXI_LENGTH), no 4 KB rule, address constant within the line. arlen = len − 1.
- After AR handshake: INCR addr += len·BPB; when line done, addr = line start + cfg_stride (modulo 2^BW_ADDR), next line.
- Tag FIFO: each AR handshake pushes 1 bit "burst ends a line"; popped on the R beat with rlast. AR issue stalls (arvalid low) while FIFO full.
- R path combinational: buf_valid = rvalid (busy only), rready = buf_ready, buf_data = {rdata, rlast & tag_head}.
- rresp ≠ 0 on any handshaked beat sets error; cleared on next accepted go. Transfer still completes.
- Last rlast handshake in DRAIN (tag FIFO empties) → done, IDLE.

## Timing
- Reset: state IDLE, busy 0, done 0, error 0, arvalid 0, araddr/arlen 0, tag FIFO empty. rready = buf_ready regardless of reset (buf_valid 0 when idle).
- arvalid asserts the cycle after go; AR fields stable while arvalid & !arready. Back-to-back ARs: next arvalid the cycle after a handshake (no bubble) if FIFO not full.
- Tag push and pop in same cycle with FIFO full: both allowed.
- busy rises the cycle after go; done is high one cycle after final R handshake, busy falls same cycle.
- go while busy ignored. Reset mid-transfer: immediate return to reset values; in-flight R beats are the system's concern.

## Test plan
- BPB=4, MAX=16: addr 0x1000, line 64, 1 line, all-ready → one AR 0x1000 len 15 INCR; 16 beats, line_last only on beat 16; done one cycle after.
- Line 80 bytes → ARs 0x1000 len 15, 0x1040 len 3; line_last only on beat 20 (not on beat 16's rlast).
- 4 KB: addr 0x1FF8, line 16 → ARs 0x1FF8 len 1, 0x2000 len 1; cfg_fixed=1 same cfg → one AR 0x1FF8 len 3 FIXED.
- 2 lines, stride 0x100, line 8, addr 0x2000 → ARs 0x2000 len 1, 0x2100 len 1; line_last on beats 2 and 4; arready held low 5 cycles → AR fields stable.
- TAG_DEPTH=2, 4 lines of 4 bytes, buf_ready=0 → exactly 2 ARs issued, arvalid low; raise buf_ready → remaining 2 ARs, done after beat 4.
- RRESP=SLVERR on beat 2 of 4 → error=1, done still pulses; next go clears error; rstnn low mid-ADDR → busy 0, arvalid 0 immediately.
